// File: rtl/aes_uart_pkg.sv
// Shared types and constants for the AES block UART transmit path.
// Define AES_TX_CHECKSUM_EN to append an XOR checksum byte to every block.
package aes_uart_pkg;

  localparam int unsigned BLOCK_BYTES = 16;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned BLOCK_W     = BLOCK_BYTES * BYTE_W;
  localparam int unsigned IDX_W       = 5;

`ifdef AES_TX_CHECKSUM_EN
  localparam int unsigned TX_BYTES = BLOCK_BYTES + 1;
`else
  localparam int unsigned TX_BYTES = BLOCK_BYTES;
`endif

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TX_BYTES - 1);
  localparam logic [IDX_W-1:0] LAST_DATA_IDX = IDX_W'(BLOCK_BYTES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StWait,
    StFinish
  } tx_state_e;

endpackage

// File: rtl/aes_block_tx_if.sv
// Request/UART handshake bundle for aes_block_tx; slave is the block, master its driver.
interface aes_block_tx_if;
  import aes_uart_pkg::*;

  logic               Start;
  logic [BLOCK_W-1:0] BlockIn;
  logic               Abort;
  logic               TxDone;
  logic [BYTE_W-1:0]  TxData;
  logic               TxStart;
  logic               Busy;
  logic               Done;
  logic [IDX_W-1:0]   ByteIdx;

  modport master (
    output Start, BlockIn, Abort, TxDone,
    input  TxData, TxStart, Busy, Done, ByteIdx
  );

  modport slave (
    input  Start, BlockIn, Abort, TxDone,
    output TxData, TxStart, Busy, Done, ByteIdx
  );

endinterface

// File: rtl/aes_block_tx.sv
// Serialises a 128-bit block MSB-first into UART bytes, one byte per TxStart/TxDone exchange.
// With AES_TX_CHECKSUM_EN defined, a 17th byte carrying the XOR of all data bytes is sent.
module aes_block_tx
  import aes_uart_pkg::*;
(
  input logic           Clk,
  input logic           Rst,
  aes_block_tx_if.slave bus
);

  tx_state_e          state_q, state_d;
  logic [BLOCK_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;
`ifdef AES_TX_CHECKSUM_EN
  logic [BYTE_W-1:0]  csum_q, csum_d;
`endif

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    byte_idx_d = byte_idx_q;
`ifdef AES_TX_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.Start) begin
          shreg_d    = bus.BlockIn;
          byte_idx_d = '0;
`ifdef AES_TX_CHECKSUM_EN
          csum_d     = '0;
`endif
          state_d    = StSend;
        end
      end
      StSend: begin
        state_d = bus.Abort ? StIdle : StWait;
      end
      StWait: begin
        // Abort beats a coincident TxDone.
        if (bus.Abort) begin
          state_d = StIdle;
        end else if (bus.TxDone) begin
          shreg_d = shreg_q << BYTE_W;
`ifdef AES_TX_CHECKSUM_EN
          csum_d  = csum_q ^ shreg_q[BLOCK_W-1 -: BYTE_W];
          // The checksum rides in the top byte so TxData needs no extra mux.
          if (byte_idx_q == LAST_DATA_IDX) begin
            shreg_d[BLOCK_W-1 -: BYTE_W] = csum_d;
          end
`endif
          // ByteIdx holds on the last byte so it never leaves its legal range.
          if (byte_idx_q == LAST_IDX) begin
            state_d = StFinish;
          end else begin
            byte_idx_d = byte_idx_q + IDX_W'(1);
            state_d    = StSend;
          end
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      byte_idx_q <= '0;
`ifdef AES_TX_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      byte_idx_q <= byte_idx_d;
`ifdef AES_TX_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign bus.TxData  = shreg_q[BLOCK_W-1 -: BYTE_W];
  assign bus.TxStart = (state_q == StSend);
  assign bus.Busy    = (state_q != StIdle);
  assign bus.Done    = (state_q == StFinish);
  assign bus.ByteIdx = byte_idx_q;

endmodule

// File: tb/tb_aes_block_tx.sv
// Self-checking bench for aes_block_tx: directed and randomized blocks against a byte-list model.
module tb_aes_block_tx;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  aes_block_tx_if bus ();

  aes_block_tx u_dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      check_eq("idle_txstart", bus.TxStart, 1'b0);
      check_eq("idle_done", bus.Done, 1'b0);
      check_eq("idle_busy", bus.Busy, 1'b0);
    end
  endtask

  // Byte list expected on the UART for a block: 16 bytes MSB-first, plus XOR when enabled.
  task automatic build_exp(input logic [127:0] blk, output logic [7:0] exp_q[$]);
    logic [7:0] x;
    exp_q = {};
    x = 8'h00;
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back(blk[127 - 8*k -: 8]);
      x = x ^ blk[127 - 8*k -: 8];
    end
`ifdef AES_TX_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  // gap: cycles between TxStart and TxDone (0 = random). *_at: byte index or -1.
  task automatic xfer(input logic [127:0] blk, input int gap_arg, input int abort_at,
                      input int restart_at, input int rst_at);
    logic [7:0] exp_q[$];
    int n;
    int gap;
    build_exp(blk, exp_q);
    n = exp_q.size();
    bus.Start   = 1'b1;
    bus.BlockIn = blk;
    bus.Abort   = 1'($urandom_range(0, 1));
    tick();
    bus.Start   = 1'b0;
    bus.Abort   = 1'b0;
    bus.BlockIn = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < n; i++) begin
      check_eq("txstart", bus.TxStart, 1'b1);
      check_eq("txdata", bus.TxData, exp_q[i]);
      check_eq("byteidx", bus.ByteIdx, 5'(i));
      check_eq("busy", bus.Busy, 1'b1);
      gap = (gap_arg > 0) ? gap_arg : int'($urandom_range(1, 6));
      for (int c = 0; c < gap; c++) begin
        if (i == rst_at && c == 0) begin
          rst = 1'b1;
          tick();
          rst = 1'b0;
          check_eq("rst_txstart", bus.TxStart, 1'b0);
          check_eq("rst_busy", bus.Busy, 1'b0);
          check_eq("rst_done", bus.Done, 1'b0);
          check_eq("rst_txdata", bus.TxData, 8'h00);
          check_eq("rst_byteidx", bus.ByteIdx, 5'd0);
          bus.TxDone = 1'b1;
          tick();
          bus.TxDone = 1'b0;
          check_eq("rst_late_txdone", bus.TxStart, 1'b0);
          check_eq("rst_late_busy", bus.Busy, 1'b0);
          idle_chk(3);
          return;
        end
        if (i == restart_at && c == 0) begin
          bus.Start   = 1'b1;
          bus.BlockIn = ~blk;
        end
        tick();
        bus.Start = 1'b0;
        check_eq("hold_txdata", bus.TxData, exp_q[i]);
        check_eq("hold_txstart", bus.TxStart, 1'b0);
        check_eq("hold_busy", bus.Busy, 1'b1);
      end
      bus.TxDone = 1'b1;
      bus.Abort  = (i == abort_at);
      tick();
      bus.TxDone = 1'b0;
      bus.Abort  = 1'b0;
      if (i == abort_at) begin
        check_eq("abort_busy", bus.Busy, 1'b0);
        check_eq("abort_txstart", bus.TxStart, 1'b0);
        check_eq("abort_done", bus.Done, 1'b0);
        idle_chk(3);
        return;
      end
      if (i == n - 1) begin
        check_eq("done_pulse", bus.Done, 1'b1);
        check_eq("done_txstart", bus.TxStart, 1'b0);
        check_eq("done_busy", bus.Busy, 1'b1);
        tick();
        check_eq("done_clear", bus.Done, 1'b0);
        check_eq("done_idle", bus.Busy, 1'b0);
        idle_chk(3);
      end
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    bus.Start   = 1'b0;
    bus.BlockIn = '0;
    bus.Abort   = 1'b0;
    bus.TxDone  = 1'b0;
    tick();
    bus.Start = 1'b1;
    bus.Abort = 1'b1;
    tick();
    bus.Start = 1'b0;
    bus.Abort = 1'b0;
    check_eq("reset_txstart", bus.TxStart, 1'b0);
    check_eq("reset_busy", bus.Busy, 1'b0);
    check_eq("reset_done", bus.Done, 1'b0);
    check_eq("reset_txdata", bus.TxData, 8'h00);
    check_eq("reset_byteidx", bus.ByteIdx, 5'd0);
    rst = 1'b0;

    // TxDone pulses while idle must be ignored.
    for (int k = 0; k < 3; k++) begin
      bus.TxDone = 1'b1;
      tick();
      bus.TxDone = 1'b0;
      check_eq("idle_txdone_txstart", bus.TxStart, 1'b0);
      check_eq("idle_txdone_busy", bus.Busy, 1'b0);
      tick();
    end

    xfer(128'h000102030405060708090a0b0c0d0e0f, 10, -1, -1, -1);
    xfer(128'h0102030405060708090a0b0c0d0e0f10, 0, -1, -1, -1);
    xfer(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0, -1, 5, -1);
    xfer({$urandom, $urandom, $urandom, $urandom}, 0, 7, -1, -1);
    xfer({$urandom, $urandom, $urandom, $urandom}, 0, -1, -1, -1);
    xfer({$urandom, $urandom, $urandom, $urandom}, 0, -1, -1, 3);
    xfer({$urandom, $urandom, $urandom, $urandom}, 0, -1, -1, -1);
    for (int r = 0; r < 6; r++) begin
      xfer({$urandom, $urandom, $urandom, $urandom}, 0,
           ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : -1,
           ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 15)) : -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_block_tx.md
AES_BLOCK_TX -- requirements
Module: aes_block_tx

Interface
REQ-001 SHALL have ports: Clk  in  1  system clock; all logic on rising edge.
REQ-002 SHALL have port: Rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have port: Start  in  1  one-cycle request to transmit BlockIn.
REQ-004 SHALL have port: BlockIn  in  128  block to send; byte 0 = BlockIn[127:120].
REQ-005 SHALL have port: Abort  in  1  terminate the current transfer.
REQ-006 SHALL have port: TxDone  in  1  one-cycle pulse from the UART transmitter when a byte's stop bit is finished.
REQ-007 SHALL have port: TxData  out  8  byte presented to the UART transmitter.
REQ-008 SHALL have port: TxStart  out  1  one-cycle pulse telling the UART transmitter to send TxData.
REQ-009 SHALL have port: Busy  out  1  high from Start acceptance until return to IDLE.
REQ-010 SHALL have port: Done  out  1  one-cycle pulse when the final byte's TxDone is received.
REQ-011 SHALL have port: ByteIdx  out  5  index of the byte currently in flight.

Function
REQ-012 SHALL implement the states IDLE, SEND, WAIT and FINISH.
REQ-013 In IDLE, Start=1 SHALL capture BlockIn into a 128-bit shift register, clear ByteIdx and go to SEND; the transfer is accepted at cycle t.
REQ-014 SEND SHALL last one cycle, assert TxStart with TxData = shreg[127:120], then go to WAIT; the first TxStart SHALL occur at t+1.
REQ-015 In WAIT, TxDone=1 SHALL shift shreg left by 8 and increment ByteIdx; if further bytes remain it SHALL go to SEND (next TxStart one cycle after TxDone), otherwise to FINISH.
REQ-016 FINISH SHALL last one cycle, assert Done=1 and return to IDLE.
REQ-017 TxData SHALL stay stable from the TxStart cycle until the matching TxDone.
REQ-018 Start SHALL be ignored while Busy=1.
REQ-019 TxDone SHALL be ignored outside WAIT.
REQ-020 Abort=1 in any non-IDLE state SHALL go to IDLE on the next edge with no further TxStart and no Done.
REQ-021 If Abort and TxDone occur in the same cycle, Abort SHALL win.
REQ-022 If Abort and Start both occur in IDLE, Start SHALL win.
REQ-023 Byte order SHALL be MSB-first, matching the receive-side shift assembly, so a received block is echoed identically.
REQ-024 ByteIdx SHALL count 0..15, or 0..16 when the checksum feature is enabled, and SHALL never wrap within a transfer.

Reset
REQ-025 Rst SHALL force IDLE and clear the shift register, TxData (to 8'h00), ByteIdx and the checksum accumulator.
REQ-026 Rst SHALL drive TxStart, Busy and Done to 0.
REQ-027 Rst SHALL take priority over Start and Abort.
REQ-028 Rst asserted mid-transfer SHALL abandon the transfer with no Done pulse.

Configuration
REQ-029 With macro AES_TX_CHECKSUM_EN defined, the block SHALL keep a running XOR of all sent bytes and send it as a 17th byte (ByteIdx=16) before FINISH.
REQ-030 Without AES_TX_CHECKSUM_EN, exactly 16 bytes SHALL be sent and no accumulator SHALL be synthesized.

Structure
REQ-031 A shared package aes_uart_pkg SHALL hold the state enum, BLOCK_BYTES=16 and BYTE_W=8.
REQ-032 No sub-module SHALL be used; the shift register, counter and FSM SHALL be one module.

Verification
REQ-033 Start with BlockIn=128'h000102030405060708090a0b0c0d0e0f, TxDone 10 cycles after each TxStart -> TxData sequence 00,01,...,0f; Done one cycle after the 16th TxDone; Busy high throughout.
REQ-034 Checksum enabled, BlockIn=128'h0102030405060708090a0b0c0d0e0f10 -> 17 bytes, last byte = 8'h10; checksum enabled, 000102...0f -> last byte = 8'h00.
REQ-035 Block 69c4e0d86a7b0430d8cdb78070b4c55a with a second Start at byte 5 -> bytes 69,c4,...,5a sent once; second Start ignored.
REQ-036 Abort coincident with the 8th TxDone -> no further TxStart, no Done, Busy=0 next cycle; a new Start is then accepted normally.
REQ-037 Rst pulse at byte 3 -> all outputs 0 next cycle; a TxDone arriving afterwards is ignored.
REQ-038 TxDone pulses injected in IDLE -> no state change, TxStart stays 0.
